mips_lite_seq_ctrl: RTL
=======================

Name: mips_lite_seq_ctrl

Overview:
- Multicycle control FSM for the MIPS_Lite core.
- Fetches 16-bit instructions over a req/ack instruction port and decodes them.
- Drives the 8x8 register file's ALU_op, rs/rt/rd selects and reg_write, and sequences data-memory accesses for load/save.
- Sits between the instruction/data memory interfaces and the register file/ALU datapath; one instruction is in flight at a time.

Parameters:
- PC_W, 8, program counter / instruction address width.
- TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetch at pc.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  instruction word: [15:13] op, [12:10] rs, [9:7] rt, [6:4] rd, [3:0] funct.
- alu_op  out  3  op field to register file/ALU.
- rs_sel  out  3  rs index.
- rt_sel  out  3  rt index.
- rd_sel  out  3  rd index.
- reg_write  out  1  register file write strobe.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory read data.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = save (store rs register), 0 = load.
- dmem_ack  in  1  data access complete.
- pc  out  PC_W  current program counter.
- busy  out  1  high in any state other than IDLE/HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async): state = IDLE; pc = 0; instruction register = 0; all outputs 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: waits for start, then goes to FETCH. start is ignored in all other states except HALT.
- FETCH:
  - imem_req = 1 with imem_addr = pc; both held stable until imem_ack.
  - On the ack cycle, latch imem_rdata into the instruction register and go to DECODE.
  - imem_req deasserts the cycle after ack.
- DECODE (1 cycle):
  - rs_sel/rt_sel/rd_sel/alu_op driven from the instruction register from this state onward, stable through the end of WB/MEM.
  - Instruction 16'hFFFF: go to HALT, pc unchanged.
- EXEC (1 cycle):
  - op != 3'b111: go to WB with wb_sel = 0.
  - op == 3'b111: go to MEM; dmem_we = funct[0].
- MEM:
  - dmem_req = 1 and dmem_we held stable until dmem_ack.
  - On ack, load (funct[0] = 0) goes to WB with wb_sel = 1.
  - On ack, save goes to FETCH with pc = pc + 1 and no register write.
- WB:
  - reg_write = 1 for exactly one cycle.
  - pc = pc + 1, wrapping modulo 2^PC_W.
  - Next state FETCH.
  - The register file picks the destination (rd for arithmetic, rs for load/save); the controller does not alter the selects.
- HALT: busy = 0, halted = 1. start resumes at FETCH with the current pc.
- Latency with zero-wait acks (ack in the first request cycle):
  - arithmetic: 4 cycles FETCH to FETCH.
  - load: 5 cycles.
  - save: 4 cycles.
- Each wait cycle adds 1 cycle.
- reg_write and dmem_req are never high in the same cycle. reg_write is never high outside WB.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0; an outstanding req is dropped.
- An ack arriving while no request is outstanding is ignored.

Optional Feature:
- Macro: MIPS_LITE_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter counts cycles imem_req or dmem_req is high without ack.
  - If the count reaches TIMEOUT_CYCLES, the request drops, err sets (sticky until rst), and state goes to HALT.
  - start from HALT still resumes, with err remaining 1.
- Undefined: no counter; requests wait indefinitely; err tied to 0.

Test Plan:
- Reset, then start pulse, instruction 16'h2A50 (op 001, rs 2, rt 4, rd 5), immediate ack -> alu_op = 001, rd_sel = 5, reg_write high exactly 4 cycles after start+1, pc 0 -> 1, wb_sel = 0.
- Load 16'hE000 (op 111, rs 0, funct 0) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we = 0, then one-cycle reg_write with wb_sel = 1, pc +1.
- Save 16'hE401 -> dmem_req with dmem_we = 1; reg_write never asserts; pc +1; next FETCH follows ack by 1 cycle.
- Fetch 16'hFFFF -> halted = 1, busy = 0, pc unchanged; a subsequent start refetches at the same pc. Separately, pc = 8'hFF after WB wraps to 8'h00.
- Assert rst while in MEM with dmem_req high -> same-cycle async clear: dmem_req = 0, state IDLE, pc = 0.
- With MIPS_LITE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, withhold imem_ack -> after 16 cycles imem_req drops, err = 1, halted = 1. Without the macro, req stays high past 100 cycles and err stays 0.

Source files
------------

// File: rtl/mips_lite_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_lite_seq_ctrl_if
//   Instruction- and data-memory handshake bundle between the MIPS_Lite
//   sequencing controller (master) and the memory subsystem (slave).
//
//   imem_req   master -> slave   instruction fetch request
//   imem_addr  master -> slave   fetch address (PC_W bits)
//   imem_ack   slave  -> master  fetch data valid this cycle
//   imem_rdata slave  -> master  16-bit instruction word
//   dmem_req   master -> slave   data memory request
//   dmem_we    master -> slave   1 = save, 0 = load
//   dmem_ack   slave  -> master  data access complete
// ---------------------------------------------------------------------------
interface mips_lite_seq_ctrl_if #(
   parameter int PC_W = 8
) ();
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/mips_lite_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mips_lite_seq_ctrl
//   Multicycle control FSM for the MIPS_Lite core. Fetches one 16-bit
//   instruction at a time over a req/ack port, decodes it, drives the
//   register-file selects / ALU op / write strobe, and sequences load/save
//   accesses on the data-memory port.
//
//   Instruction word: [15:13] op, [12:10] rs, [9:7] rt, [6:4] rd, [3:0] funct
//   op 3'b111 is a memory op (funct[0] = 1 save, 0 load); 16'hFFFF halts.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, leaves IDLE/HALT and fetches at pc
//   mem        if   master side of mips_lite_seq_ctrl_if (imem/dmem handshakes)
//   alu_op     out  op field to ALU/register file
//   rs_sel     out  rs index
//   rt_sel     out  rt index
//   rd_sel     out  rd index
//   reg_write  out  one-cycle register-file write strobe (WB only)
//   wb_sel     out  write-back source: 0 = ALU, 1 = memory read data
//   pc         out  program counter (also the fetch address)
//   busy       out  high in every state other than IDLE/HALT
//   halted     out  high in HALT
//   err        out  sticky memory-timeout flag
//
// Optional feature (macro MIPS_LITE_CTRL_TIMEOUT_EN)
//   When defined, a request that waits TIMEOUT_CYCLES cycles without ack is
//   dropped, err sets (sticky until rst) and the FSM parks in HALT. When
//   undefined, requests wait indefinitely and err is tied low.
// ---------------------------------------------------------------------------
module mips_lite_seq_ctrl #(
   parameter int PC_W           = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   mips_lite_seq_ctrl_if.master mem,
   output logic [2:0]           alu_op,
   output logic [2:0]           rs_sel,
   output logic [2:0]           rt_sel,
   output logic [2:0]           rd_sel,
   output logic                 reg_write,
   output logic                 wb_sel,
   output logic [PC_W-1:0]      pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [2:0]  OP_MEM     = 3'b111;
   localparam logic [15:0] INSTR_HALT = 16'hFFFF;

   state_t      state;
   logic [15:0] ir;
   logic [2:0]  ir_op;
   logic        ir_save;

   assign ir_op   = ir[15:13];
   assign ir_save = ir[0];

   // pc only changes outside FETCH, so the address is stable for the whole
   // request without a separate register.
   assign mem.imem_addr = pc;
   assign busy          = (state != S_IDLE) && (state != S_HALT);
   assign halted        = (state == S_HALT);

`ifdef MIPS_LITE_CTRL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_expired;

   // Final un-acked cycle of the allowed window: the request is high for
   // exactly TIMEOUT_CYCLES cycles before it drops.
   assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
   assign err = 1'b0;
`endif

   // NOTE: every register here is updated with non-blocking assignments so
   // that all branches see the pre-edge values of state, pc and ir.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         pc           <= '0;
         ir           <= '0;
         alu_op       <= '0;
         rs_sel       <= '0;
         rt_sel       <= '0;
         rd_sel       <= '0;
         reg_write    <= 1'b0;
         wb_sel       <= 1'b0;
         mem.imem_req <= 1'b0;
         mem.dmem_req <= 1'b0;
         mem.dmem_we  <= 1'b0;
`ifdef MIPS_LITE_CTRL_TIMEOUT_EN
         wait_cnt     <= '0;
         err          <= 1'b0;
`endif
      end else begin
         // NOTE: reg_write defaults low every cycle and is re-armed only on
         // the transition into WB, which makes it a single-cycle strobe.
         reg_write <= 1'b0;
`ifdef MIPS_LITE_CTRL_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state        <= S_FETCH;
                  mem.imem_req <= 1'b1;
               end
            end

            S_FETCH: begin
               if (mem.imem_ack) begin
                  // Selects come straight from the fetched word so they are
                  // already valid during DECODE.
                  ir           <= mem.imem_rdata;
                  alu_op       <= mem.imem_rdata[15:13];
                  rs_sel       <= mem.imem_rdata[12:10];
                  rt_sel       <= mem.imem_rdata[9:7];
                  rd_sel       <= mem.imem_rdata[6:4];
                  mem.imem_req <= 1'b0;
                  state        <= S_DECODE;
               end
`ifdef MIPS_LITE_CTRL_TIMEOUT_EN
               else if (wait_expired) begin
                  mem.imem_req <= 1'b0;
                  err          <= 1'b1;
                  state        <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`endif
            end

            S_DECODE: begin
               state <= (ir == INSTR_HALT) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
               if (ir_op == OP_MEM) begin
                  state        <= S_MEM;
                  mem.dmem_req <= 1'b1;
                  mem.dmem_we  <= ir_save;
               end else begin
                  state     <= S_WB;
                  wb_sel    <= 1'b0;
                  reg_write <= 1'b1;
               end
            end

            S_MEM: begin
               if (mem.dmem_ack) begin
                  mem.dmem_req <= 1'b0;
                  mem.dmem_we  <= 1'b0;
                  if (ir_save) begin
                     // A save writes nothing back, so it retires here.
                     pc           <= pc + PC_W'(1);
                     state        <= S_FETCH;
                     mem.imem_req <= 1'b1;
                  end else begin
                     state     <= S_WB;
                     wb_sel    <= 1'b1;
                     reg_write <= 1'b1;
                  end
               end
`ifdef MIPS_LITE_CTRL_TIMEOUT_EN
               else if (wait_expired) begin
                  mem.dmem_req <= 1'b0;
                  mem.dmem_we  <= 1'b0;
                  err          <= 1'b1;
                  state        <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`endif
            end

            S_WB: begin
               pc           <= pc + PC_W'(1);
               state        <= S_FETCH;
               mem.imem_req <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
